// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU write-back stage.
// Entry layout is {dst, addr, data}, dst in the MSB.
package alu_wb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REG_WR = 2'd1,
    MEM_WR = 2'd2
  } wb_state_e;

  localparam logic DST_REG = 1'b0;
  localparam logic DST_MEM = 1'b1;

  localparam int WB_DW = 8;
  localparam int WB_AW = 8;

  typedef struct packed {
    logic             dst;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic int entry_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO; pointers carry one extra wrap bit for full/empty.
module wb_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] wp, rp;
  logic [W-1:0]  mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[IW] != rp[IW]) && (wp[IW-1:0] == rp[IW-1:0]);
  assign rdata = mem[rp[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[IW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_writeback.sv
// Write-back stage: buffers ALU results and commits each, in order, to the
// register file (one-cycle strobe) or data RAM (held until mem_ack).
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [DW-1:0] res_data,
  input  logic          res_dst,
  input  logic [AW-1:0] res_addr,
  output logic          reg_we,
  output logic [AW-1:0] reg_waddr,
  output logic [DW-1:0] reg_wdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic          busy
);
  localparam int EW = entry_w(AW, DW);

  wb_state_e     state;
  logic [EW-1:0] head;
  logic          full, empty, push, pop;

  assign res_ready = !full;
  assign push      = res_valid && !full;
  // Head leaves the FIFO as it is loaded into the output registers, so the
  // entry being committed does not occupy a FIFO slot.
  assign pop       = (state == IDLE) && !empty;
  assign busy      = !empty || (state != IDLE);

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({res_dst, res_addr, res_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head[EW-1] == DST_MEM) begin
              mem_we    <= 1'b1;
              mem_addr  <= head[DW +: AW];
              mem_wdata <= head[DW-1:0];
              state     <= MEM_WR;
            end else begin
              reg_we    <= 1'b1;
              reg_waddr <= head[DW +: AW];
              reg_wdata <= head[DW-1:0];
              state     <= REG_WR;
            end
          end
        end
        REG_WR: begin
          reg_we <= 1'b0;
          state  <= IDLE;
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
